snoop_bus_ctrl: RTL and testbench
=================================

Name: snoop_bus_ctrl

Overview:
Parametrised N-core snoop bus controller for the MOESI cache system, sitting between the per-core cache controllers and the shared snoop broadcast.
- Accepts requests via a valid/ready handshake under round-robin arbitration.
- Latches the winning request and broadcasts it for a programmable number of cycles.
- Collects snoop responses from every other core, bounded by a timeout.
- Returns a combined shared/dirty result to the requester.

Parameters:
- NUM_CORES, 4, number of cores; 1..16, any value (non-power-of-2 allowed).
- ADDR_WIDTH, 64, request address width.
- TYPE_WIDTH, 2, bus request type width; encoding in coh_bus_pkg.
- BCAST_CYCLES, 2, cycles bus_valid is held per transaction; must be >=1.
- SNOOP_TIMEOUT, 16, max cycles spent in SNOOP_WAIT; must be >=1.
- ID_W, max(1,$clog2(NUM_CORES)), derived core id width; localparam.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req_valid  in  NUM_CORES  per-core request valid
- core_req_type  in  NUM_CORES x TYPE_WIDTH  per-core request type
- core_req_addr  in  NUM_CORES x ADDR_WIDTH  per-core request address
- core_req_ready  out  NUM_CORES  one-hot accept strobe
- bus_valid  out  1  broadcast valid
- bus_type  out  TYPE_WIDTH  latched request type
- bus_addr  out  ADDR_WIDTH  latched request address
- bus_src_id  out  ID_W  requesting core id
- snp_resp_valid  in  NUM_CORES  per-core snoop response strobe
- snp_resp_shared  in  NUM_CORES  responder holds the line (S/O/E/M)
- snp_resp_dirty  in  NUM_CORES  responder holds the line dirty (O/M); will supply data
- done_valid  out  1  one-cycle transaction completion pulse
- done_id  out  ID_W  core id of completed transaction
- done_shared  out  1  OR of shared responses
- done_dirty  out  1  OR of dirty responses
- done_timeout  out  1  completion forced by timeout

Behaviour:
- Reset: clk is the clock; rst_n is an asynchronous, active-low reset.
  - On reset: state=IDLE, rr_ptr=0, all counters and masks 0.
  - All outputs are 0, including core_req_ready, bus_* and done_*.
  - Reset mid-transaction aborts it with no done pulse.
- States: IDLE -> BCAST -> SNOOP_WAIT -> DONE -> IDLE.
- IDLE:
  - core_req_ready is combinational one-hot of the round-robin winner, searched from rr_ptr upward with wrap modulo NUM_CORES.
  - It is 0 when no request is valid; it is 0 in every other state.
  - Accept = valid&ready. On accept, latch type/addr/id, load pending = all-ones minus the requester bit, clear shared/dirty accumulators, load bcast_cnt=BCAST_CYCLES-1, go to BCAST.
  - rr_ptr <= (winner+1) mod NUM_CORES; explicit wrap for non-power-of-2.
- BCAST:
  - bus_valid=1, with bus_type/addr/src_id stable from latched copies, never live inputs.
  - Decrement bcast_cnt; at 0, go to SNOOP_WAIT and load to_cnt=SNOOP_TIMEOUT-1.
- Response collection, in BCAST and SNOOP_WAIT only:
  - snp_resp_valid[i] with pending[i]=1 clears pending[i] and ORs shared[i]/dirty[i] into the accumulators.
  - Responses from the requester, duplicates, or any response in IDLE/DONE are ignored.
- SNOOP_WAIT:
  - bus_valid=0.
  - The exit check uses the mask value including this cycle's responses.
  - If pending==0, go to DONE; else if to_cnt==0, go to DONE with timeout flag set; else decrement to_cnt.
  - A final response and timeout expiry in the same cycle count as not timed out.
- DONE:
  - done_valid=1 for exactly one cycle with done_id, done_shared, done_dirty, done_timeout. Then IDLE.
  - done_* are 0 whenever done_valid=0.
- Latency:
  - Accept at cycle T gives bus_valid on T+1..T+BCAST_CYCLES.
  - The earliest done_valid is T+BCAST_CYCLES+2.
  - Next accept occurs no earlier than the cycle after done.
- NUM_CORES=1: pending is empty at accept, so SNOOP_WAIT lasts one cycle and done_shared=done_dirty=0.
- Protocol: a core holds valid/type/addr stable until ready. The block does not depend on this because data is latched at accept.

Decomposition:
- coh_bus_pkg holds:
  - the state enum snoop_bus_state_t;
  - bus request type encodings BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3;
  - the TYPE_WIDTH default constant.
- One sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot grant, grant_id, any. It is purely combinational.
- Top module: FSM, latches, counters, response mask.

Test Plan:
- Single request, core2 valid addr=0x1000 type=BUS_RD, cores 0/1/3 respond shared=0 on cycle T+2 -> ready[2] at T; bus_valid T+1..T+2 with addr=0x1000, src_id=2; done_valid T+4 with id=2, shared=0, dirty=0, timeout=0.
- All four cores requesting continuously -> grant order 0,1,2,3,0; each ready pulses once per transaction; no core is granted twice before the others.
- NUM_CORES=3, cores 1 and 2 requesting -> order 1,2,1 (rr_ptr wraps 2->0), never id 3.
- Core1 responds dirty=1, core3 shared=1, core2 never responds, SNOOP_TIMEOUT=16 -> done_valid exactly 16 cycles after SNOOP_WAIT entry with shared=1, dirty=1, timeout=1.
- Requester self-response plus a duplicate response from core0 -> both ignored; done waits for the remaining cores.
- rst_n dropped during BCAST -> bus_valid, ready and done are 0 immediately; no done pulse; first post-reset grant is the lowest valid core from rr_ptr=0.

Source files
------------

// File: rtl/coh_bus_pkg.sv
// Shared types and encodings for the MOESI snoop bus.
package coh_bus_pkg;

    localparam int unsigned COH_TYPE_WIDTH = 2;

    // Bus request type encodings
    localparam logic [COH_TYPE_WIDTH-1:0] BUS_RD   = 2'd0;
    localparam logic [COH_TYPE_WIDTH-1:0] BUS_RDX  = 2'd1;
    localparam logic [COH_TYPE_WIDTH-1:0] BUS_UPGR = 2'd2;
    localparam logic [COH_TYPE_WIDTH-1:0] BUS_WB   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BCAST      = 2'd1,
        ST_SNOOP_WAIT = 2'd2,
        ST_DONE       = 2'd3
    } snoop_bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// otherwise the lowest requester below ptr (wrap modulo N).
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    // Two passes: upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1]
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (ID_W'(j) >= ptr)) begin
                grant[j] = 1'b1;
                grant_id = ID_W'(j);
                any      = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (ID_W'(j) < ptr)) begin
                grant[j] = 1'b1;
                grant_id = ID_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// N-core snoop bus controller: arbitrate, broadcast, collect snoop responses, report.
module snoop_bus_ctrl
    import coh_bus_pkg::*;
#(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned TYPE_WIDTH    = COH_TYPE_WIDTH,
    parameter int unsigned BCAST_CYCLES  = 2,
    parameter int unsigned SNOOP_TIMEOUT = 16,
    localparam int unsigned ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CORES-1:0]                 core_req_valid,
    input  logic [NUM_CORES-1:0][TYPE_WIDTH-1:0] core_req_type,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_req_addr,
    output logic [NUM_CORES-1:0]                 core_req_ready,
    output logic                                 bus_valid,
    output logic [TYPE_WIDTH-1:0]                bus_type,
    output logic [ADDR_WIDTH-1:0]                bus_addr,
    output logic [ID_W-1:0]                      bus_src_id,
    input  logic [NUM_CORES-1:0]                 snp_resp_valid,
    input  logic [NUM_CORES-1:0]                 snp_resp_shared,
    input  logic [NUM_CORES-1:0]                 snp_resp_dirty,
    output logic                                 done_valid,
    output logic [ID_W-1:0]                      done_id,
    output logic                                 done_shared,
    output logic                                 done_dirty,
    output logic                                 done_timeout
);

    localparam int unsigned BC_W = (BCAST_CYCLES > 1) ? $clog2(BCAST_CYCLES) : 1;
    localparam int unsigned TO_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

    snoop_bus_state_t        state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         src_q, src_d;
    logic [TYPE_WIDTH-1:0]   type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_CORES-1:0]    pending_q, pending_d;
    logic                    shared_q, shared_d;
    logic                    dirty_q, dirty_d;
    logic                    timeout_q, timeout_d;
    logic [BC_W-1:0]         bcast_cnt_q, bcast_cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

    logic [NUM_CORES-1:0]    grant;
    logic [ID_W-1:0]         grant_id;
    logic                    grant_any;
    logic [TYPE_WIDTH-1:0]   win_type;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [NUM_CORES-1:0]    resp_hit;
    logic [NUM_CORES-1:0]    pending_nxt;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req      (core_req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    // Select the winning core's request payload from the one-hot grant
    always_comb begin
        win_type = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                win_type = core_req_type[i];
                win_addr = core_req_addr[i];
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            src_q       <= '0;
            type_q      <= '0;
            addr_q      <= '0;
            pending_q   <= '0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
            timeout_q   <= 1'b0;
            bcast_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            src_q       <= src_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            pending_q   <= pending_d;
            shared_q    <= shared_d;
            dirty_q     <= dirty_d;
            timeout_q   <= timeout_d;
            bcast_cnt_q <= bcast_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Next state, request latch, counters and response accumulation
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        src_d       = src_q;
        type_d      = type_q;
        addr_d      = addr_q;
        timeout_d   = timeout_q;
        bcast_cnt_d = bcast_cnt_q;
        to_cnt_d    = to_cnt_q;

        // Only first responses from still-pending cores count, and only while snooping
        resp_hit    = ((state_q == ST_BCAST) || (state_q == ST_SNOOP_WAIT))
                      ? (snp_resp_valid & pending_q) : '0;
        pending_nxt = pending_q & ~resp_hit;
        pending_d   = pending_nxt;
        shared_d    = shared_q | (|(resp_hit & snp_resp_shared));
        dirty_d     = dirty_q  | (|(resp_hit & snp_resp_dirty));

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d     = ST_BCAST;
                    type_d      = win_type;
                    addr_d      = win_addr;
                    src_d       = grant_id;
                    pending_d   = ~grant;
                    shared_d    = 1'b0;
                    dirty_d     = 1'b0;
                    timeout_d   = 1'b0;
                    bcast_cnt_d = BC_W'(BCAST_CYCLES - 1);
                    rr_ptr_d    = (grant_id == ID_W'(NUM_CORES - 1)) ? '0
                                                                     : grant_id + ID_W'(1);
                end
            end
            ST_BCAST: begin
                if (bcast_cnt_q == '0) begin
                    state_d  = ST_SNOOP_WAIT;
                    to_cnt_d = TO_W'(SNOOP_TIMEOUT - 1);
                end else begin
                    bcast_cnt_d = bcast_cnt_q - BC_W'(1);
                end
            end
            ST_SNOOP_WAIT: begin
                // A last response arriving on the expiry cycle wins over the timeout
                if (pending_nxt == '0) begin
                    state_d = ST_DONE;
                end else if (to_cnt_q == '0) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; ready is masked during reset
    always_comb begin
        core_req_ready = '0;
        bus_valid      = 1'b0;
        bus_type       = '0;
        bus_addr       = '0;
        bus_src_id     = '0;
        done_valid     = 1'b0;
        done_id        = '0;
        done_shared    = 1'b0;
        done_dirty     = 1'b0;
        done_timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n) begin
                    core_req_ready = grant;
                end
            end
            ST_BCAST: begin
                bus_valid  = 1'b1;
                bus_type   = type_q;
                bus_addr   = addr_q;
                bus_src_id = src_q;
            end
            ST_DONE: begin
                done_valid   = 1'b1;
                done_id      = src_q;
                done_shared  = shared_q;
                done_dirty   = dirty_q;
                done_timeout = timeout_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl (4-core and 3-core instances).
module tb_snoop_bus_ctrl;
    import coh_bus_pkg::*;

    localparam int unsigned NC  = 4;
    localparam int unsigned NC3 = 3;
    localparam int unsigned AW  = 64;
    localparam int unsigned TW  = 2;
    localparam int unsigned IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           sh;
        logic           dt;
        logic           to;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]          req_valid;
    logic [NC-1:0][TW-1:0]  req_type;
    logic [NC-1:0][AW-1:0]  req_addr;
    logic [NC-1:0]          ready;
    logic                   bus_valid;
    logic [TW-1:0]          bus_type;
    logic [AW-1:0]          bus_addr;
    logic [IDW-1:0]         bus_src;
    logic [NC-1:0]          rv, rs, rd;
    logic                   done_valid, done_shared, done_dirty, done_timeout;
    logic [IDW-1:0]         done_id;

    logic [NC3-1:0]         req_valid3;
    logic [NC3-1:0][TW-1:0] req_type3;
    logic [NC3-1:0][AW-1:0] req_addr3;
    logic [NC3-1:0]         ready3;
    logic                   bus_valid3;
    logic [TW-1:0]          bus_type3;
    logic [AW-1:0]          bus_addr3;
    logic [IDW-1:0]         bus_src3;
    logic [NC3-1:0]         rv3, rs3, rd3;
    logic                   done_valid3, done_shared3, done_dirty3, done_timeout3;
    logic [IDW-1:0]         done_id3;

    snoop_bus_ctrl #(.NUM_CORES(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(req_valid), .core_req_type(req_type), .core_req_addr(req_addr),
        .core_req_ready(ready),
        .bus_valid(bus_valid), .bus_type(bus_type), .bus_addr(bus_addr), .bus_src_id(bus_src),
        .snp_resp_valid(rv), .snp_resp_shared(rs), .snp_resp_dirty(rd),
        .done_valid(done_valid), .done_id(done_id), .done_shared(done_shared),
        .done_dirty(done_dirty), .done_timeout(done_timeout)
    );

    snoop_bus_ctrl #(.NUM_CORES(NC3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(req_valid3), .core_req_type(req_type3), .core_req_addr(req_addr3),
        .core_req_ready(ready3),
        .bus_valid(bus_valid3), .bus_type(bus_type3), .bus_addr(bus_addr3), .bus_src_id(bus_src3),
        .snp_resp_valid(rv3), .snp_resp_shared(rs3), .snp_resp_dirty(rd3),
        .done_valid(done_valid3), .done_id(done_id3), .done_shared(done_shared3),
        .done_dirty(done_dirty3), .done_timeout(done_timeout3)
    );

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned gnt_seen = 0;
    int unsigned gnt_seen3 = 0;
    int unsigned exp_gnt[$];
    int unsigned exp_gnt3[$];
    done_t       exp_done[$];
    bit          auto_resp = 1'b0;
    bit          auto_resp3 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic done_t mk_done(input int unsigned id, input bit sh, input bit dt, input bit to);
        done_t d;
        d.id = IDW'(id);
        d.sh = sh;
        d.dt = dt;
        d.to = to;
        return d;
    endfunction

    task automatic wait_grants(input int unsigned target, input bit three);
        int unsigned n = 0;
        while (((three ? gnt_seen3 : gnt_seen) < target) && (n < 300)) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(three ? "wait_grants3" : "wait_grants",
            64'((three ? gnt_seen3 : gnt_seen) >= target), 64'(1));
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_done.size() != 0) && (n < 300)) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_drain", 64'(exp_done.size()), 64'(0));
    endtask

    // Grant monitor (4-core): every ready pulse must match the next expected winner
    always @(negedge clk) begin
        if (ready != '0) begin
            gnt_seen++;
            if (exp_gnt.size() == 0) begin
                chk("grant_unexpected", 64'(ready), 64'(0));
            end else begin
                chk("grant", 64'(ready), 64'(1) << exp_gnt.pop_front());
            end
        end
    end

    // Grant monitor (3-core)
    always @(negedge clk) begin
        if (ready3 != '0) begin
            gnt_seen3++;
            if (exp_gnt3.size() == 0) begin
                chk("grant3_unexpected", 64'(ready3), 64'(0));
            end else begin
                chk("grant3", 64'(ready3), 64'(1) << exp_gnt3.pop_front());
            end
        end
    end

    // Completion monitor: compare each done pulse, and require quiet done_* otherwise
    always @(negedge clk) begin
        if (done_valid) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", 64'(done_valid), 64'(0));
            end else begin
                chk("done_fields", 64'({done_id, done_shared, done_dirty, done_timeout}),
                    64'(exp_done.pop_front()));
            end
        end else begin
            chk("done_idle_zero", 64'({done_id, done_shared, done_dirty, done_timeout}), 64'(0));
        end
    end

    // Optional responders: every core answers clean while its bus broadcasts
    always @(posedge clk) begin
        #1;
        if (auto_resp) begin
            rv = bus_valid ? '1 : '0;
            rs = '0;
            rd = '0;
        end
        if (auto_resp3) begin
            rv3 = bus_valid3 ? '1 : '0;
            rs3 = '0;
            rd3 = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = '0;
        req_type   = '0;
        req_addr   = '0;
        rv = '0; rs = '0; rd = '0;
        req_valid3 = '0;
        req_type3  = '0;
        req_addr3  = '0;
        rv3 = '0; rs3 = '0; rd3 = '0;

        // Reset: ready must stay low even with requests present
        req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'(0));
        chk("reset_bus", 64'({bus_valid, bus_addr}), 64'(0));
        chk("reset_done", 64'(done_valid), 64'(0));
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // Continuous requests from all cores: order 0,1,2,3,0
        auto_resp = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt.push_back(k % 4);
            exp_done.push_back(mk_done(k % 4, 1'b0, 1'b0, 1'b0));
        end
        tick();
        for (int i = 0; i < NC; i++) begin
            req_addr[i] = 64'h100 * i;
            req_type[i] = BUS_RD;
        end
        req_valid = '1;
        wait_grants(5, 1'b0);
        tick();
        req_valid = '0;
        wait_drain();
        auto_resp = 1'b0;
        tick();
        rv = '0;

        // Single request from core2; latched bus payload, done at T+4
        tick();
        req_valid[2] = 1'b1;
        req_addr[2]  = 64'h1000;
        req_type[2]  = BUS_RD;
        exp_gnt.push_back(2);
        exp_done.push_back(mk_done(2, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("t1_ready", 64'(ready), 64'b0100);
        tick();                                  // T+1
        req_valid   = '0;
        req_addr[2] = 64'hDEAD_BEEF;
        req_type[2] = BUS_WB;
        @(negedge clk);
        chk("t1_bus_valid1", 64'(bus_valid), 64'(1));
        chk("t1_bus_addr", bus_addr, 64'h1000);
        chk("t1_bus_src", 64'(bus_src), 64'(2));
        chk("t1_bus_type", 64'(bus_type), 64'(BUS_RD));
        tick();                                  // T+2
        rv = 4'b1011;
        rs = '0;
        rd = '0;
        @(negedge clk);
        chk("t1_bus_valid2", 64'(bus_valid), 64'(1));
        chk("t1_bus_addr2", bus_addr, 64'h1000);
        tick();                                  // T+3
        rv = '0;
        @(negedge clk);
        chk("t1_bus_off", 64'(bus_valid), 64'(0));
        chk("t1_done_early", 64'(done_valid), 64'(0));
        tick();                                  // T+4
        @(negedge clk);
        chk("t1_done_at_t4", 64'(done_valid), 64'(1));
        tick();

        // Timeout: core1 dirty, core3 shared, core2 silent; done 16 cycles after SNOOP_WAIT entry
        tick();
        req_valid[0] = 1'b1;
        req_addr[0]  = 64'h2000;
        req_type[0]  = BUS_RDX;
        exp_gnt.push_back(0);
        exp_done.push_back(mk_done(0, 1'b1, 1'b1, 1'b1));
        tick();                                  // T+1
        req_valid = '0;
        rv = 4'b1010;
        rs = 4'b1010;
        rd = 4'b0010;
        tick();                                  // T+2
        rv = '0; rs = '0; rd = '0;
        tick();                                  // T+3: SNOOP_WAIT entry
        @(negedge clk);
        chk("to_bus_off", 64'(bus_valid), 64'(0));
        repeat (15) tick();                      // T+18
        @(negedge clk);
        chk("to_not_yet", 64'(done_valid), 64'(0));
        tick();                                  // T+19
        @(negedge clk);
        chk("to_done_at_16", 64'(done_valid), 64'(1));
        tick();

        // Self-response and duplicate response ignored; done waits for cores 2 and 3
        tick();
        req_valid[1] = 1'b1;
        req_addr[1]  = 64'h3000;
        req_type[1]  = BUS_UPGR;
        exp_gnt.push_back(1);
        exp_done.push_back(mk_done(1, 1'b0, 1'b0, 1'b0));
        tick();                                  // T+1
        req_valid = '0;
        rv = 4'b0011; rs = 4'b0010; rd = 4'b0010;
        tick();                                  // T+2
        rv = 4'b0001; rs = 4'b0001; rd = 4'b0001;
        tick();                                  // T+3
        rv = '0; rs = '0; rd = '0;
        tick();                                  // T+4
        rv = 4'b1100;
        @(negedge clk);
        chk("dup_not_done", 64'(done_valid), 64'(0));
        tick();                                  // T+5
        rv = '0;
        @(negedge clk);
        chk("dup_done", 64'(done_valid), 64'(1));
        tick();

        // Reset during BCAST: aborted with no done; post-reset grant restarts from core 0
        tick();
        req_valid = 4'b1010;
        req_addr[3] = 64'h4000;
        req_addr[1] = 64'h5000;
        exp_gnt.push_back(3);
        tick();                                  // BCAST
        @(negedge clk);
        chk("rst_pre_bus", 64'(bus_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_bus_off", 64'(bus_valid), 64'(0));
        chk("rst_ready_off", 64'(ready), 64'(0));
        chk("rst_done_off", 64'(done_valid), 64'(0));
        repeat (2) tick();
        exp_gnt.push_back(1);
        exp_done.push_back(mk_done(1, 1'b0, 1'b0, 1'b0));
        auto_resp = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", 64'(ready), 64'b0010);
        tick();
        req_valid = '0;
        wait_drain();
        auto_resp = 1'b0;
        tick();
        rv = '0;

        // 3-core instance: cores 1 and 2 requesting -> 1,2,1
        auto_resp3 = 1'b1;
        exp_gnt3.push_back(1);
        exp_gnt3.push_back(2);
        exp_gnt3.push_back(1);
        tick();
        req_valid3 = 3'b110;
        wait_grants(3, 1'b1);
        tick();
        req_valid3 = '0;
        repeat (10) tick();
        auto_resp3 = 1'b0;
        rv3 = '0;

        repeat (10) tick();
        chk("left_grants", 64'(exp_gnt.size() + exp_gnt3.size()), 64'(0));
        chk("left_dones", 64'(exp_done.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
